branch_cond_unit: RTL and testbench

Parametrised, pipelined successor to the CPU's combinational branch comparator. It evaluates a branch condition on two register operands or a register and an immediate. Conditions are selectable signed or unsigned. It also owns a bank of hardware loop counters (load / decrement-and-branch) and a saved compare-flags register for deferred branches. It sits between the register-read stage and the PC-update logic, using a valid/ready handshake on both sides.

---
 rtl/branch_cond_unit.sv | 128 ++++++++++++
 tb/tb_branch_cond_unit.sv | 142 ++++++++++++++
 2 files changed

// File: rtl/branch_cond_unit.sv
// Pipelined branch-condition evaluator with hardware loop counters and saved compare flags.
// One output register; a result is accepted whenever the output slot is empty or being drained.
module branch_cond_unit #(
    parameter int WIDTH     = 16,
    parameter int NUM_CTRS  = 2,
    parameter int CTR_SEL_W = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     rddata,
    input  logic [WIDTH-1:0]     rsdata,
    input  logic [WIDTH-1:0]     n_imm,
    input  logic [3:0]           cond,
    input  logic                 sgn,
    input  logic [CTR_SEL_W-1:0] ctr_sel,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 jump,
    output logic [2:0]           flags
);

    typedef enum logic [3:0] {
        C_GT     = 4'b0000, C_LT    = 4'b0001, C_EQ   = 4'b0010, C_NE   = 4'b0011,
        C_ZERO   = 4'b0100, C_NEG   = 4'b0101, C_GE   = 4'b0110, C_LE   = 4'b0111,
        C_GT_I   = 4'b1000, C_LT_I  = 4'b1001, C_EQ_I = 4'b1010, C_NE_I = 4'b1011,
        C_LLOAD  = 4'b1100, C_LDEC  = 4'b1101, C_SETF = 4'b1110, C_FBR  = 4'b1111
    } cond_e;

    logic             out_valid_q, out_valid_d;
    logic             jump_q, jump_d;
    logic [2:0]       flags_q, flags_d;
    logic [WIDTH-1:0] ctr_q [NUM_CTRS];
    logic [WIDTH-1:0] ctr_d [NUM_CTRS];

    logic             accept;
    logic [WIDTH-1:0] op_b, a_x, b_x, rs_x;
    logic             gt, lt, eq;
    logic             gt_rs, lt_rs, eq_rs;
    logic             ctr_hit;
    logic [WIDTH-1:0] ctr_cur;

    assign in_ready  = !out_valid_q || out_ready;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign jump      = jump_q;
    assign flags     = flags_q;

    // Signed compare = unsigned compare with the sign bits inverted.
    assign op_b  = cond[3] ? n_imm : rsdata;
    assign a_x   = {rddata[WIDTH-1] ^ sgn, rddata[WIDTH-2:0]};
    assign b_x   = {op_b[WIDTH-1] ^ sgn, op_b[WIDTH-2:0]};
    assign rs_x  = {rsdata[WIDTH-1] ^ sgn, rsdata[WIDTH-2:0]};
    assign gt    = a_x > b_x;
    assign lt    = a_x < b_x;
    assign eq    = rddata == op_b;
    assign gt_rs = a_x > rs_x;
    assign lt_rs = a_x < rs_x;
    assign eq_rs = rddata == rsdata;

    // Selected counter lookup; out-of-range selects simply never hit.
    always_comb begin
        ctr_hit = 1'b0;
        ctr_cur = '0;
        for (int i = 0; i < NUM_CTRS; i++) begin
            if (CTR_SEL_W'(i) == ctr_sel) begin
                ctr_hit = 1'b1;
                ctr_cur = ctr_q[i];
            end
        end
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        jump_d      = jump_q;
        flags_d     = flags_q;
        ctr_d       = ctr_q;
        out_valid_d = out_valid_q;
        if (accept) begin
            out_valid_d = 1'b1;
            jump_d      = 1'b0;
            unique case (cond_e'(cond))
                C_GT, C_GT_I: jump_d = gt;
                C_LT, C_LT_I: jump_d = lt;
                C_EQ, C_EQ_I: jump_d = eq;
                C_NE, C_NE_I: jump_d = !eq;
                C_ZERO:       jump_d = rddata == '0;
                C_NEG:        jump_d = rddata[WIDTH-1];
                C_GE:         jump_d = !lt;
                C_LE:         jump_d = !gt;
                C_LLOAD: begin
                    for (int i = 0; i < NUM_CTRS; i++)
                        if (CTR_SEL_W'(i) == ctr_sel) ctr_d[i] = rddata;
                end
                C_LDEC: begin
                    if (ctr_hit && ctr_cur != '0) begin
                        jump_d = ctr_cur != WIDTH'(1);
                        for (int i = 0; i < NUM_CTRS; i++)
                            if (CTR_SEL_W'(i) == ctr_sel) ctr_d[i] = ctr_cur - WIDTH'(1);
                    end
                end
                C_SETF:       flags_d = {gt_rs, lt_rs, eq_rs};
                C_FBR:        jump_d = |(flags_q & n_imm[2:0]);
                default:      jump_d = 1'b0;
            endcase
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // NOTE: state registers use non-blocking assignments; the counter bank is
    // architecturally visible, so it is reset along with the control state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            jump_q      <= 1'b0;
            flags_q     <= 3'b000;
            for (int i = 0; i < NUM_CTRS; i++) ctr_q[i] <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            jump_q      <= jump_d;
            flags_q     <= flags_d;
            ctr_q       <= ctr_d;
        end
    end

endmodule

// File: tb/tb_branch_cond_unit.sv
// Directed-vector bench for branch_cond_unit with hand-computed expectations.
module tb_branch_cond_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] rddata, rsdata, n_imm;
    logic [3:0]  cond;
    logic        sgn;
    logic [0:0]  ctr_sel;
    logic        out_valid;
    logic        out_ready;
    logic        jump;
    logic [2:0]  flags;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_cond_unit #(.WIDTH(16), .NUM_CTRS(2), .CTR_SEL_W(1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rddata(rddata), .rsdata(rsdata), .n_imm(n_imm), .cond(cond), .sgn(sgn),
        .ctr_sel(ctr_sel), .out_valid(out_valid), .out_ready(out_ready),
        .jump(jump), .flags(flags)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input logic [3:0] c, input logic s, input logic [15:0] a,
                           input logic [15:0] b, input logic [15:0] imm, input logic sel);
        cond = c; sgn = s; rddata = a; rsdata = b; n_imm = imm; ctr_sel = sel;
        in_valid = 1'b1;
    endtask

    // One request, accepted on the next edge, result checked just after it.
    task automatic send(input string tag, input logic [3:0] c, input logic s,
                        input logic [15:0] a, input logic [15:0] b, input logic [15:0] imm,
                        input logic sel, input logic exp_jump);
        @(negedge clk);
        set_req(c, s, a, b, imm, sel);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check({tag, "_valid"}, out_valid, 1);
        check(tag, jump, exp_jump);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        rddata = '0; rsdata = '0; n_imm = '0; cond = '0; sgn = 1'b0; ctr_sel = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_jump", jump, 0);
        check("rst_flags", flags, 0);
        check("rst_ready", in_ready, 1);
        @(negedge clk) rst_n = 1'b1;

        send("gt_uns",  4'b0000, 0, 16'hFFFF, 16'h0001, 16'h0, 0, 1);
        send("gt_sgn",  4'b0000, 1, 16'hFFFF, 16'h0001, 16'h0, 0, 0);
        send("neg",     4'b0101, 0, 16'h8000, 16'h0000, 16'h0, 0, 1);
        send("eq_imm",  4'b1010, 0, 16'h0042, 16'h0000, 16'h0042, 0, 1);
        send("ge_sgn",  4'b0110, 1, 16'hFFFE, 16'hFFFE, 16'h0, 0, 1);
        send("le",      4'b0111, 0, 16'd5,    16'd3,    16'h0, 0, 0);
        send("gt_imm",  4'b1000, 0, 16'd3,    16'd9,    16'd2, 0, 1);
        send("lt_sgn",  4'b0001, 1, 16'h8000, 16'h7FFF, 16'h0, 0, 1);
        send("zero",    4'b0100, 0, 16'h0000, 16'h1234, 16'h0, 0, 1);
        send("ne",      4'b0011, 0, 16'h0010, 16'h0010, 16'h0, 0, 0);
        @(posedge clk); #1;
        check("drain_valid", out_valid, 0);

        // Loop counter 1 loaded with 3, counter 0 untouched.
        send("lload",  4'b1100, 0, 16'd3, 16'h0, 16'h0, 1, 0);
        send("ldec1",  4'b1101, 0, 16'h0, 16'h0, 16'h0, 1, 1);
        send("ldec2",  4'b1101, 0, 16'h0, 16'h0, 16'h0, 1, 1);
        send("ldec3",  4'b1101, 0, 16'h0, 16'h0, 16'h0, 1, 0);
        send("ldec4",  4'b1101, 0, 16'h0, 16'h0, 16'h0, 1, 0);
        send("ldec_c0", 4'b1101, 0, 16'h0, 16'h0, 16'h0, 0, 0);

        // Backpressure: a stalled LOOP_DEC must decrement exactly once.
        send("bp_load", 4'b1100, 0, 16'd3, 16'h0, 16'h0, 1, 0);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        set_req(4'b1101, 0, 16'h0, 16'h0, 16'h0, 1);
        @(posedge clk); #1;
        check("bp_acc_jump", jump, 1);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check("bp_hold_valid", out_valid, 1);
            check("bp_hold_ready", in_ready, 0);
            check("bp_hold_jump", jump, 1);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("bp_second_jump", jump, 1);
        send("bp_third", 4'b1101, 0, 16'h0, 16'h0, 16'h0, 1, 0);

        // Saved flags and deferred branch.
        send("setf", 4'b1110, 0, 16'd7, 16'd9, 16'h0, 0, 0);
        check("setf_flags", flags, 3'b010);
        send("fbr_hit",  4'b1111, 0, 16'h0, 16'h0, 16'b010, 0, 1);
        send("fbr_miss", 4'b1111, 0, 16'h0, 16'h0, 16'b101, 0, 0);
        send("setf_sgn", 4'b1110, 1, 16'hFFFF, 16'h0001, 16'h0, 0, 0);
        check("setf_sgn_flags", flags, 3'b010);

        // Reset while a result is stalled.
        send("rm_load", 4'b1100, 0, 16'd5, 16'h0, 16'h0, 0, 0);
        send("rm_setf", 4'b1110, 0, 16'd9, 16'd7, 16'h0, 0, 0);
        check("rm_flags", flags, 3'b100);
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        set_req(4'b0000, 0, 16'd9, 16'd7, 16'h0, 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rm_pending", out_valid, 1);
        @(negedge clk) rst_n = 1'b0;
        @(posedge clk); #1;
        check("rm_valid", out_valid, 0);
        check("rm_jump", jump, 0);
        check("rm_flags0", flags, 0);
        check("rm_ready", in_ready, 1);
        @(negedge clk) begin rst_n = 1'b1; out_ready = 1'b1; end
        send("rm_ldec", 4'b1101, 0, 16'h0, 16'h0, 16'h0, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
